vga_pixel_fetch: RTL and testbench

Downstream pixel stage of the VGA display path. Consumes the horizontal/vertical counts and the sync/enable outputs of the VGA timing FSM, then computes framebuffer read addresses for a 2× upscaled image. It issues reads to a synchronous framebuffer RAM and emits RGB pixels with sync signals delayed to stay aligned. It also owns the double-buffer bank select, swapped only in vertical blank through a request/acknowledge handshake.

---
 rtl/vga_pixel_fetch.sv | 135 +++++++++++++
 tb/tb_vga_pixel_fetch.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage: maps VGA counts to a 2x upscaled framebuffer, keeps syncs aligned
// with RAM read latency, and swaps the displayed bank only at the vertical-blank swap point.
module vga_pixel_fetch #(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int ADDR_W  = 17,
    parameter int PIX_W   = 8,
    parameter int MEM_LAT = 1,
    parameter int VACTIVE = 480
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [9:0]        h_cnt_i,
    input  logic [9:0]        v_cnt_i,
    input  logic              hs_i,
    input  logic              vs_i,
    input  logic              d_ena_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    output logic              mem_bank_o,
    input  logic [PIX_W-1:0]  mem_data_i,
    input  logic [PIX_W-1:0]  border_i,
    input  logic              swap_req_i,
    output logic              swap_ack_o,
    output logic [PIX_W-1:0]  rgb_o,
    output logic              hs_o,
    output logic              vs_o,
    output logic              d_ena_o,
    output logic              frame_start_o
);

    // Side-band word layout: {frame, vs, hs, d_ena, in_image, border}
    localparam int B_IN = PIX_W;
    localparam int B_DE = PIX_W + 1;
    localparam int B_HS = PIX_W + 2;
    localparam int B_VS = PIX_W + 3;
    localparam int B_FS = PIX_W + 4;
    localparam int SB_W = PIX_W + 5;
    localparam logic [31:0] C_IMG_W = 32'(IMG_W);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_DONE} state_t;

    // y*IMG_W + x as a sum of shifted copies of y, one per set bit of the constant width
    function automatic logic [ADDR_W-1:0] f_addr(input logic [9:0] x, input logic [9:0] y);
        logic [ADDR_W-1:0] acc;
        acc = ADDR_W'(x);
        for (int i = 0; i < 32; i++) begin
            if (C_IMG_W[i]) acc = acc + (ADDR_W'(y) << i);
        end
        return acc;
    endfunction

    logic [9:0]        w_x;
    logic [9:0]        w_y;
    logic              w_in_img;
    logic              w_fs;
    logic              w_swap_pt;
    logic [SB_W-1:0]   w_out;

    logic [ADDR_W-1:0] r_addr;
    logic              r_rd;
    logic [SB_W-1:0]   r_a;
    logic [SB_W-1:0]   r_b [MEM_LAT];
    state_t            r_state;
    logic              r_bank;
    logic              r_ack;

    assign w_x       = {1'b0, h_cnt_i[9:1]};
    assign w_y       = {1'b0, v_cnt_i[9:1]};
    assign w_in_img  = d_ena_i && (int'(w_x) < IMG_W) && (int'(w_y) < IMG_H);
    assign w_fs      = (h_cnt_i == 10'd0) && (v_cnt_i == 10'd0);
    assign w_swap_pt = (h_cnt_i == 10'd0) && (v_cnt_i == 10'(VACTIVE));

    // Stage A: address/strobe out to the RAM, side-band captured with the pixel
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr <= '0;
            r_rd   <= 1'b0;
            r_a    <= '0;
        end else begin
            r_addr <= f_addr(w_x, w_y);
            r_rd   <= w_in_img;
            r_a    <= {w_fs, vs_i, hs_i, d_ena_i, w_in_img, border_i};
        end
    end

    // Stage B: side-band rides alongside the MEM_LAT-cycle RAM access
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MEM_LAT; i++) r_b[i] <= '0;
        end else begin
            r_b[0] <= r_a;
            for (int i = 1; i < MEM_LAT; i++) r_b[i] <= r_b[i-1];
        end
    end

    assign w_out = r_b[MEM_LAT-1];

    always_comb begin
        rgb_o = '0;
        if (w_out[B_DE]) rgb_o = w_out[B_IN] ? mem_data_i : w_out[PIX_W-1:0];
    end

    assign mem_addr_o    = r_addr;
    assign mem_rd_o      = r_rd;
    assign hs_o          = w_out[B_HS];
    assign vs_o          = w_out[B_VS];
    assign d_ena_o       = w_out[B_DE];
    assign frame_start_o = w_out[B_FS];

    // A request seen in IDLE costs one cycle, so one arriving on the swap point waits a frame
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_bank  <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: if (swap_req_i) r_state <= S_PEND;
                S_PEND: if (w_swap_pt) begin
                    r_bank  <= ~r_bank;
                    r_ack   <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: if (!swap_req_i) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_bank_o = r_bank;
    assign swap_ack_o = r_ack;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench: two instances (default geometry/MEM_LAT=1 and 256x200/MEM_LAT=2)
// share one stimulus stream; expected pixels come from plain-arithmetic models.
module tb_vga_pixel_fetch;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic [9:0] h_cnt = '0;
    logic [9:0] v_cnt = '0;
    logic       hs = 1'b0, vs = 1'b0, de = 1'b0, req = 1'b0;
    logic [7:0] border = '0;

    logic [16:0] addr_a, addr_b;
    logic        rd_a, rd_b, bank_a, bank_b, ack_a, ack_b;
    logic [7:0]  rgb_a, rgb_b, data_a, data_b;
    logic        hs_a, hs_b, vs_a, vs_b, de_a, de_b, fs_a, fs_b;
    logic [7:0]  ra0, rb0, rb1;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, sp_cyc = -1;
    int ack_cnt_a = 0, ack_cnt_b = 0, ack_cyc_a = -1, ack_cyc_b = -1;
    logic [9:0] v_samp = '0;
    logic bank_pa = 1'b0, bank_pb = 1'b0, rst_q = 1'b0;

    typedef struct { int due; logic [7:0] rgb; logic hs, vs, de, fs; } out_t;
    typedef struct { int due; logic rd; int addr; } mem_t;
    out_t qoa[$], qob[$];
    mem_t qma[$], qmb[$];

    always #5 clk = ~clk;

    vga_pixel_fetch dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .h_cnt_i(h_cnt), .v_cnt_i(v_cnt),
        .hs_i(hs), .vs_i(vs), .d_ena_i(de),
        .mem_addr_o(addr_a), .mem_rd_o(rd_a), .mem_bank_o(bank_a), .mem_data_i(data_a),
        .border_i(border), .swap_req_i(req), .swap_ack_o(ack_a), .rgb_o(rgb_a),
        .hs_o(hs_a), .vs_o(vs_a), .d_ena_o(de_a), .frame_start_o(fs_a));

    vga_pixel_fetch #(.IMG_W(256), .IMG_H(200), .MEM_LAT(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .h_cnt_i(h_cnt), .v_cnt_i(v_cnt),
        .hs_i(hs), .vs_i(vs), .d_ena_i(de),
        .mem_addr_o(addr_b), .mem_rd_o(rd_b), .mem_bank_o(bank_b), .mem_data_i(data_b),
        .border_i(border), .swap_req_i(req), .swap_ack_o(ack_b), .rgb_o(rgb_b),
        .hs_o(hs_b), .vs_o(vs_b), .d_ena_o(de_b), .frame_start_o(fs_b));

    // RAM models return the low address byte after 1 and 2 cycles respectively
    always @(posedge clk) begin
        ra0 <= addr_a[7:0];
        rb0 <= addr_b[7:0];
        rb1 <= rb0;
    end
    assign data_a = ra0;
    assign data_b = rb1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    function automatic out_t model_out(input int w, input int ht, input int h, input int v,
                                       input bit hs_, input bit vs_, input bit de_,
                                       input logic [7:0] bd, input int due);
        out_t o;
        int x, y;
        logic [31:0] a;
        bit inimg;
        x = h / 2;
        y = v / 2;
        inimg = de_ && (x < w) && (y < ht);
        a = 32'(y * w + x);
        o.due = due;
        o.hs = hs_;
        o.vs = vs_;
        o.de = de_;
        o.fs = (h == 0) && (v == 0);
        o.rgb = !de_ ? 8'd0 : (inimg ? a[7:0] : bd);
        return o;
    endfunction

    function automatic mem_t model_mem(input int w, input int ht, input int h, input int v,
                                       input bit de_, input int due);
        mem_t m;
        m.due = due;
        m.rd = de_ && (h / 2 < w) && (v / 2 < ht);
        m.addr = (v / 2) * w + h / 2;
        return m;
    endfunction

    task automatic drive(input int h, input int v, input bit hs_, input bit vs_, input bit de_,
                         input bit rq, input int xa_a = -1, input int xr_a = -1);
        out_t oa;
        mem_t ma;
        @(posedge clk);
        #1;
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        hs = hs_;
        vs = vs_;
        de = de_;
        req = rq;
        border = 8'($urandom);
        if (h == 0 && v == 480) sp_cyc = cyc;
        if (rst_ni) begin
            oa = model_out(320, 240, h, v, hs_, vs_, de_, border, cyc + 2);
            if (xr_a >= 0) oa.rgb = 8'(xr_a);
            ma = model_mem(320, 240, h, v, de_, cyc + 1);
            if (xa_a >= 0) ma.addr = xa_a;
            qoa.push_back(oa);
            qma.push_back(ma);
            qob.push_back(model_out(256, 200, h, v, hs_, vs_, de_, border, cyc + 3));
            qmb.push_back(model_mem(256, 200, h, v, de_, cyc + 1));
        end
    endtask

    task automatic mini_frame(input bit r0, input bit r1, input bit r2);
        for (int h = 0; h < 6; h++) drive(h, 0, 1, 1, 1, r0);
        for (int h = 0; h < 4; h++) drive(h * 37, 100, 0, 0, 1, r1);
        drive(638, 479, 0, 0, 1, r1);
        drive(639, 479, 0, 0, 1, r1);
        drive(0, 480, 0, 0, 0, r2);
        drive(1, 480, 0, 0, 0, r2);
        drive(5, 490, 0, 1, 0, r2);
    endtask

    task automatic reset_checks(input string t);
        chk({t, ".A.rgb"}, 32'(rgb_a), 0);   chk({t, ".B.rgb"}, 32'(rgb_b), 0);
        chk({t, ".A.hs"}, 32'(hs_a), 0);     chk({t, ".B.hs"}, 32'(hs_b), 0);
        chk({t, ".A.vs"}, 32'(vs_a), 0);     chk({t, ".B.vs"}, 32'(vs_b), 0);
        chk({t, ".A.de"}, 32'(de_a), 0);     chk({t, ".B.de"}, 32'(de_b), 0);
        chk({t, ".A.rd"}, 32'(rd_a), 0);     chk({t, ".B.rd"}, 32'(rd_b), 0);
        chk({t, ".A.ack"}, 32'(ack_a), 0);   chk({t, ".B.ack"}, 32'(ack_b), 0);
        chk({t, ".A.bank"}, 32'(bank_a), 0); chk({t, ".B.bank"}, 32'(bank_b), 0);
        chk({t, ".A.fs"}, 32'(fs_a), 0);     chk({t, ".B.fs"}, 32'(fs_b), 0);
    endtask

    task automatic swap_checks(input string t, input int n_ack, input bit bank_exp);
        chk({t, ".A.acks"}, 32'(ack_cnt_a), 32'(n_ack));
        chk({t, ".B.acks"}, 32'(ack_cnt_b), 32'(n_ack));
        chk({t, ".A.bank"}, 32'(bank_a), 32'(bank_exp));
        chk({t, ".B.bank"}, 32'(bank_b), 32'(bank_exp));
    endtask

    // Scoreboard monitor: pops every entry whose output cycle has arrived
    always @(negedge clk) begin : monitor
        out_t e;
        mem_t m;
        while (qoa.size() > 0 && qoa[0].due <= cyc) begin
            e = qoa.pop_front();
            chk("A.rgb", 32'(rgb_a), 32'(e.rgb)); chk("A.hs", 32'(hs_a), 32'(e.hs));
            chk("A.vs", 32'(vs_a), 32'(e.vs));    chk("A.de", 32'(de_a), 32'(e.de));
            chk("A.fs", 32'(fs_a), 32'(e.fs));
        end
        while (qob.size() > 0 && qob[0].due <= cyc) begin
            e = qob.pop_front();
            chk("B.rgb", 32'(rgb_b), 32'(e.rgb)); chk("B.hs", 32'(hs_b), 32'(e.hs));
            chk("B.vs", 32'(vs_b), 32'(e.vs));    chk("B.de", 32'(de_b), 32'(e.de));
            chk("B.fs", 32'(fs_b), 32'(e.fs));
        end
        while (qma.size() > 0 && qma[0].due <= cyc) begin
            m = qma.pop_front();
            chk("A.rd", 32'(rd_a), 32'(m.rd));
            if (m.rd) chk("A.addr", 32'(addr_a), m.addr);
        end
        while (qmb.size() > 0 && qmb[0].due <= cyc) begin
            m = qmb.pop_front();
            chk("B.rd", 32'(rd_b), 32'(m.rd));
            if (m.rd) chk("B.addr", 32'(addr_b), m.addr);
        end
    end

    always @(posedge clk) begin
        v_samp  <= v_cnt;
        bank_pa <= bank_a;
        bank_pb <= bank_b;
        rst_q   <= rst_ni;
    end

    always @(negedge clk) begin
        if (ack_a) begin ack_cnt_a++; ack_cyc_a = cyc; end
        if (ack_b) begin ack_cnt_b++; ack_cyc_b = cyc; end
        if (rst_ni && rst_q && v_samp < 10'd480) begin
            chk("A.bank_hold", 32'(bank_a), 32'(bank_pa));
            chk("B.bank_hold", 32'(bank_b), 32'(bank_pb));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        reset_checks("rst0");
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;

        // Address map corners, explicit constants for the default geometry
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(3, 5, 0, 0, 1, 0, 641);
        drive(639, 479, 0, 0, 1, 0, 76799);
        drive(1, 0, 0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 1, 0, 0);

        // hsync pulse of 96 cycles across a line sweep
        for (int h = 0; h < 200; h++) drive(h, 0, h < 96, 0, 1, 0, -1, (h == 10) ? 5 : -1);

        // Border and blanking corners
        drive(600, 100, 0, 0, 1, 0);
        drive(600, 410, 0, 0, 1, 0);
        drive(100, 100, 0, 0, 0, 0);
        drive(511, 399, 1, 0, 1, 0);
        drive(512, 400, 0, 1, 1, 0);
        drive(700, 600, 1, 1, 1, 0);

        repeat (1200) begin
            int h, v;
            h = $urandom_range(0, 1023);
            v = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 1023) : $urandom_range(0, 479);
            drive(h, v, 1'($urandom), 1'($urandom), 1'($urandom), 0);
        end

        mini_frame(0, 0, 0);
        swap_checks("idle", 0, 0);

        mini_frame(0, 1, 1);
        swap_checks("swap1", 1, 1);
        chk("A.ack_time1", 32'(ack_cyc_a), 32'(sp_cyc + 1));
        chk("B.ack_time1", 32'(ack_cyc_b), 32'(sp_cyc + 1));

        mini_frame(1, 1, 1);
        mini_frame(1, 1, 1);
        swap_checks("held", 1, 1);

        repeat (3) drive(10, 10, 0, 0, 1, 0);
        mini_frame(0, 1, 1);
        swap_checks("swap2", 2, 0);

        repeat (3) drive(10, 10, 0, 0, 1, 0);
        mini_frame(0, 0, 1);
        swap_checks("late_req", 2, 0);
        mini_frame(1, 1, 1);
        swap_checks("swap3", 3, 1);
        chk("A.ack_time3", 32'(ack_cyc_a), 32'(sp_cyc + 1));

        // Leave a swap pending, then reset mid-line with live outputs
        repeat (2) drive(20, 0, 1, 1, 1, 0);
        repeat (3) drive(20, 0, 1, 1, 1, 1);
        @(posedge clk);
        #3 rst_ni = 1'b0;
        qoa.delete(); qob.delete(); qma.delete(); qmb.delete();
        #1;
        reset_checks("rst1");
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        req = 1'b0;
        drive(30, 30, 0, 0, 1, 0);
        mini_frame(0, 0, 0);
        swap_checks("after_rst", 3, 0);

        repeat (200) begin
            drive($urandom_range(0, 799), $urandom_range(0, 524),
                  1'($urandom), 1'($urandom), 1'($urandom), 0);
        end

        repeat (6) @(negedge clk);
        chk("drain", 32'(qoa.size() + qob.size() + qma.size() + qmb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
